mult_div_unit: RTL

//  Iterative MIPS multiply/divide unit. Owns the HI/LO register pair.

---
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Multiply is shift-add and divide is restoring division, one bit per cycle.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start, op      request an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b           rs / rt operands, sampled only in the start cycle
//   hi_we, lo_we   MTHI / MTLO writes of a, honoured only in IDLE without start
//   busy, done     operation in progress / one-cycle result pulse
//   hi, lo         HI / LO registers
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;     // product / quotient must be negated
  logic             neg_r;     // remainder must be negated
  logic             div_zero;
  logic [WIDTH-1:0] acc;       // product upper half / partial remainder
  logic [WIDTH-1:0] work;      // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] opnd;      // |multiplicand| or |divisor|

  // Operand magnitudes for the start cycle; op[0]==0 selects signed ops
  logic             sgn_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign sgn_op = ~op[0];
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? WIDTH'(-a) : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? WIDTH'(-b) : b;

  // One multiply step: conditionally add, then shift {carry,acc,work} right
  logic [WIDTH:0] msum;
  assign msum = {1'b0, acc} + (work[0] ? {1'b0, opnd} : '0);

  // One restoring divide step: shift next dividend bit in, subtract if it fits
  logic [WIDTH:0] dshift;
  logic [WIDTH:0] ddiff;
  logic           dfit;
  assign dshift = {acc, work[WIDTH-1]};
  assign ddiff  = dshift - {1'b0, opnd};
  assign dfit   = (dshift >= {1'b0, opnd});

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_q ? (2*WIDTH)'(-{acc, work}) : {acc, work};
  assign quo_fix  = div_zero ? '1 : (neg_q ? WIDTH'(-work) : work);
  assign rem_fix  = neg_r ? WIDTH'(-acc) : acc;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (count == CW'(WIDTH - 1)) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      work     <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_q    <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= sgn_op & a[WIDTH-1];
            div_zero <= op[1] & (b == '0);
            acc      <= '0;
            count    <= '0;
            busy     <= 1'b1;
            // Divide shifts the dividend out of work; multiply shifts the multiplier
            work     <= op[1] ? a_mag : b_mag;
            opnd     <= op[1] ? b_mag : a_mag;
          end else begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
          end
        end
        S_CALC: begin
          count <= count + CW'(1);
          if (is_div) begin
            acc  <= dfit ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
            work <= {work[WIDTH-2:0], dfit};
          end else begin
            acc  <= msum[WIDTH:1];
            work <= {msum[0], work[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
